// File: rtl/store_merger_pkg.sv
// Shared types for the store merger: access size, FSM state,
// and the alignment rule for sub-doubleword stores.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Byte stores are always aligned; wider ones need zero low bits.
  function automatic logic misaligned(
    input size_t      sz,
    input logic [2:0] a
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      sz == SZ_H: m = a[0];
      sz == SZ_W: m = |a[1:0];
      sz == SZ_D: m = |a[2:0];
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_merger_if.sv
// Request and memory-port bundle of the store merger.
// master = control/memory side, slave = store_merger.
interface store_merger_if #(
  parameter int DATA_W = 64
);

  logic              start;
  logic [1:0]        size;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output start, size, addr, wdata,
    output mem_rdata,
    input  busy, done, err,
    input  mem_addr, mem_re,
    input  mem_we, mem_wdata
  );

  modport slave (
    input  start, size, addr, wdata,
    input  mem_rdata,
    output busy, done, err,
    output mem_addr, mem_re,
    output mem_we, mem_wdata
  );

endinterface

// File: rtl/store_merger_lane_merge.sv
// Replaces the low lanes of a memory word with store data,
// keeping the upper lanes of the previously read word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [63:0] rbuf,
  input  logic [63:0] wdata,
  input  size_t       size,
  output logic [63:0] merged
);

  always_comb begin
    merged = wdata;
    unique case (1'b1)
      size == SZ_B: merged = {rbuf[63:8],  wdata[7:0]};
      size == SZ_H: merged = {rbuf[63:16], wdata[15:0]};
      size == SZ_W: merged = {rbuf[63:32], wdata[31:0]};
      default:      merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_merger.sv
// Store path: byte/half/word stores read-modify-write the
// addressed 64-bit word, doubleword stores write directly.
module store_merger
  import store_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  store_merger_if.slave  bus
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(RD_LAT);

  state_t            state_q, state_d;
  size_t             size_q, size_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] merged;

  // Merge on next-state values so an sd from IDLE
  // sees the request data in the same edge.
  store_lane_merge u_merge (
    .rbuf   (rbuf_d),
    .wdata  (wdata_d),
    .size   (size_d),
    .merged (merged)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          size_d  = size_t'(bus.size);
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = '0;
          if (misaligned(size_d, bus.addr[2:0]))
            state_d = S_DONE;
          else if (size_d == SZ_D)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAT) begin
          rbuf_d  = bus.mem_rdata;
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state.
  always_comb begin
    busy_d      = state_d != S_IDLE;
    done_d      = state_d == S_DONE;
    mem_re_d    = state_d == S_READ;
    mem_we_d    = state_d == S_WRITE;
    err_d       = done_d &&
                  misaligned(size_d, addr_d[2:0]);
    mem_addr_d  = busy_d ? addr_d : '0;
    mem_wdata_d = mem_we_d ? merged : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_B;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merger.sv
// Directed bench for store_merger at RD_LAT=1 and RD_LAT=3.
// Memory side returns poison except on the exact latency cycle.
module tb_store_merger;
  import store_pkg::*;

  localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_merger_if ifa ();
  store_merger_if ifb ();

  store_merger #(.DATA_W(64), .RD_LAT(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  store_merger #(.DATA_W(64), .RD_LAT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  bit          sel = 1'b0;
  int          lat_s = 1;
  logic        busy_s, done_s, err_s, re_s, we_s;
  logic [63:0] wd_s, maddr_s;

  assign busy_s  = sel ? ifb.busy      : ifa.busy;
  assign done_s  = sel ? ifb.done      : ifa.done;
  assign err_s   = sel ? ifb.err       : ifa.err;
  assign re_s    = sel ? ifb.mem_re    : ifa.mem_re;
  assign we_s    = sel ? ifb.mem_we    : ifa.mem_we;
  assign wd_s    = sel ? ifb.mem_wdata : ifa.mem_wdata;
  assign maddr_s = sel ? ifb.mem_addr  : ifa.mem_addr;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic drive(input logic st, input logic [1:0] sz,
                       input logic [63:0] ad,
                       input logic [63:0] wd);
    if (sel) begin
      ifb.start = st; ifb.size = sz;
      ifb.addr = ad;  ifb.wdata = wd;
    end else begin
      ifa.start = st; ifa.size = sz;
      ifa.addr = ad;  ifa.wdata = wd;
    end
  endtask

  task automatic drive_rd(input logic [63:0] v);
    if (sel) ifb.mem_rdata = v;
    else     ifa.mem_rdata = v;
  endtask

  int          dcyc, wecyc, nre, nwe;
  logic        err_o;
  logic [63:0] wout, aout;

  // Issue one store from a negedge; cycle c = c-th cycle after the start edge.
  task automatic store(input logic [1:0] sz, input logic [63:0] ad,
                       input logic [63:0] wd, input logic [63:0] rv,
                       input bit poke);
    dcyc = -1; wecyc = -1; nre = 0; nwe = 0;
    err_o = 1'b0; wout = '0; aout = '0;
    drive(1'b1, sz, ad, wd);
    drive_rd(POISON);
    @(posedge clk); @(negedge clk);
    drive(1'b0, ~sz, ~ad, ~wd);
    for (int c = 1; c <= 20; c++) begin
      if (re_s) begin
        drive_rd(nre == lat_s ? rv : POISON);
        nre++;
        aout = maddr_s;
      end else begin
        drive_rd(POISON);
      end
      if (we_s) begin
        nwe++; wout = wd_s; wecyc = c; aout = maddr_s;
      end
      if (done_s) begin
        dcyc = c; err_o = err_s;
        break;
      end
      if (poke && busy_s) drive(1'b1, SZ_D, ad ^ 64'h8, wd);
      @(posedge clk); @(negedge clk);
    end
    drive(1'b0, sz, ad, wd);
    @(posedge clk); @(negedge clk);
    check("idle_busy", 64'(busy_s), 64'd0);
    check("idle_we", 64'(we_s), 64'd0);
  endtask

  initial begin
    ifa.start = 0; ifa.size = 0; ifa.addr = 0;
    ifa.wdata = 0; ifa.mem_rdata = 0;
    ifb.start = 0; ifb.size = 0; ifb.addr = 0;
    ifb.wdata = 0; ifb.mem_rdata = 0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(ifa.busy), 64'd0);
    check("rst_done", 64'(ifa.done), 64'd0);
    check("rst_err", 64'(ifa.err), 64'd0);
    check("rst_re", 64'(ifa.mem_re), 64'd0);
    check("rst_we", 64'(ifa.mem_we), 64'd0);
    check("rst_addr", ifa.mem_addr, 64'd0);
    check("rst_wdata", ifa.mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 1'b0; lat_s = 1;
    store(SZ_B, 64'h10, 64'hAB, 64'h1122334455667788, 1'b0);
    check("sb_data", wout, 64'h11223344556677AB);
    check("sb_nwe", 64'(nwe), 64'd1);
    check("sb_nre", 64'(nre), 64'd2);
    check("sb_done", 64'(dcyc), 64'd4);
    check("sb_err", 64'(err_o), 64'd0);
    check("sb_addr", aout, 64'h10);
    check("idle_addr", maddr_s, 64'd0);

    store(SZ_B, 64'h13, 64'h5A5A5A5A5A5A5A3C, 64'd0, 1'b0);
    check("sb_odd_data", wout, 64'h000000000000003C);
    check("sb_odd_err", 64'(err_o), 64'd0);

    store(SZ_H, 64'h20, 64'h12345678, '1, 1'b0);
    check("sh_data", wout, 64'hFFFFFFFFFFFF5678);
    check("sh_done", 64'(dcyc), 64'd4);

    store(SZ_W, 64'h28, 64'h12345678, '1, 1'b0);
    check("sw_data", wout, 64'hFFFFFFFF12345678);
    check("sw_nwe", 64'(nwe), 64'd1);

    store(SZ_D, 64'h18, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0);
    check("sd_nre", 64'(nre), 64'd0);
    check("sd_wecyc", 64'(wecyc), 64'd1);
    check("sd_done", 64'(dcyc), 64'd2);
    check("sd_data", wout, 64'hDEADBEEFCAFEF00D);
    check("sd_addr", aout, 64'h18);

    store(SZ_W, 64'h1E, 64'h1, 64'd0, 1'b0);
    check("mis_sw_done", 64'(dcyc), 64'd1);
    check("mis_sw_err", 64'(err_o), 64'd1);
    check("mis_sw_nre", 64'(nre), 64'd0);
    check("mis_sw_nwe", 64'(nwe), 64'd0);
    check("mis_err_clr", 64'(err_s), 64'd0);

    store(SZ_H, 64'h11, 64'h1, 64'd0, 1'b0);
    check("mis_sh_err", 64'(err_o), 64'd1);
    store(SZ_D, 64'h1C, 64'h1, 64'd0, 1'b0);
    check("mis_sd_err", 64'(err_o), 64'd1);
    check("mis_sd_nwe", 64'(nwe), 64'd0);

    sel = 1'b1; lat_s = 3;
    store(SZ_B, 64'h40, 64'hCD, 64'h0102030405060708, 1'b1);
    check("lat3_nre", 64'(nre), 64'd4);
    check("lat3_done", 64'(dcyc), 64'd6);
    check("lat3_nwe", 64'(nwe), 64'd1);
    check("lat3_data", wout, 64'h01020304050607CD);

    drive(1'b1, SZ_B, 64'h48, 64'h77);
    drive_rd(POISON);
    @(posedge clk); @(negedge clk);
    drive(1'b0, SZ_B, 64'h48, 64'h77);
    @(posedge clk); @(negedge clk);
    check("pre_rst_re", 64'(re_s), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy_s), 64'd0);
    check("rst_mid_re", 64'(re_s), 64'd0);
    check("rst_mid_we", 64'(we_s), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    store(SZ_B, 64'h50, 64'h99, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    check("post_rst_data", wout, 64'hAAAAAAAAAAAAAA99);
    check("post_rst_done", 64'(dcyc), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
